mem_xfer_fsm: RTL and testbench

- Parametrised load/store sequencer for the microcontroller datapath. Generalises the single-mode store controller.
- Drives register-file tri-state enables, MAR/MDR latch strobes and the memory EN/RW pair to move one word between a selected register and memory.
- Adds load mode, a generic register count, a mem_ready handshake with timeout, abort, and error reporting.
- Sits beside the fetch/decode controller, which issues start with decoded selects.

---
 rtl/mem_xfer_pkg.sv | 23 ++
 rtl/reg_onehot_dec.sv | 20 ++
 rtl/mem_xfer_fsm.sv | 169 ++++++++++++++++
 tb/tb_mem_xfer_fsm.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types and constants for the load/store sequencer.
// The state encoding is also exported on the debug port of mem_xfer_fsm.
package mem_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4,
      WB    = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic MODE_STORE = 1'b0;
   localparam logic MODE_LOAD  = 1'b1;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int NUM_REGS_DEF = 5;

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-select decoder: a one-hot enable gated by en, plus a range check
// that is independent of en.
module reg_onehot_dec #(
   parameter int SEL_W    = 6,
   parameter int NUM_REGS = 5
) (
   input  logic [SEL_W-1:0]    sel,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot,
   output logic                valid
);

   always_comb begin
      valid = int'(sel) < NUM_REGS;
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot[i] = en && (int'(sel) == i);
      end
   end

endmodule

// File: rtl/mem_xfer_fsm.sv
// Load/store sequencer: moves one word between a selected register and memory,
// with a mem_ready handshake, a bounded wait, abort and error reporting.
module mem_xfer_fsm
   import mem_xfer_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int SEL_W    = 6,
   parameter int TIMEOUT  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [SEL_W-1:0]    addr_sel,
   input  logic [SEL_W-1:0]    data_sel,
   input  logic                mem_ready,
   input  logic                abort,
   output logic [NUM_REGS-1:0] RegOutEn,
   output logic [NUM_REGS-1:0] RegInEn,
   output logic                MARin,
   output logic                MDR_frombusin,
   output logic                MDR_frommemin,
   output logic                MDRout,
   output logic                EN,
   output logic                RW,
   output logic                busy,
   output logic                done,
   output logic                err,
   output state_t              state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nx;
   logic              mode_q;
   logic [SEL_W-1:0]  addr_q, data_q;
   logic [CNT_W-1:0]  cnt;
   logic              err_q;

   logic [SEL_W-1:0]    addr_dec_sel, data_dec_sel;
   logic [NUM_REGS-1:0] addr_oh, data_oh;
   logic                addr_valid, data_valid;
   logic                in_mem, mem_timeout, take_start, bad_start;

   // In IDLE the decoders look at the live selects only for the range check;
   // their one-hot outputs are gated off there, so nothing reaches the ports.
   assign addr_dec_sel = (state == IDLE) ? addr_sel : addr_q;
   assign data_dec_sel = (state == IDLE) ? data_sel : data_q;

   reg_onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_addr_dec (
      .sel    (addr_dec_sel),
      .en     (state == ADDR),
      .onehot (addr_oh),
      .valid  (addr_valid)
   );

   reg_onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_data_dec (
      .sel    (data_dec_sel),
      .en     ((state == DATA) || (state == WB)),
      .onehot (data_oh),
      .valid  (data_valid)
   );

   assign in_mem      = (state == WRITE) || (state == READ);
   assign mem_timeout = in_mem && !mem_ready && (cnt == CNT_LAST);
   assign take_start  = (state == IDLE) && start && !abort;
   assign bad_start   = take_start && !(addr_valid && data_valid);
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_STORE;
         addr_q <= '0;
         data_q <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (take_start) begin
            mode_q <= mode;
            addr_q <= addr_sel;
            data_q <= data_sel;
         end
         // ADDR/DATA always precede a memory state, so clearing there is the entry load.
         if ((state == ADDR) || (state == DATA)) begin
            cnt <= '0;
         end else if (in_mem) begin
            cnt <= cnt + 1'b1;
         end
         if (abort || (state == DONE)) begin
            err_q <= 1'b0;
         end else if (bad_start || mem_timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:  if (start) state_nx = (addr_valid && data_valid) ? ADDR : DONE;
            ADDR:  state_nx = (mode_q == MODE_LOAD) ? READ : DATA;
            DATA:  state_nx = WRITE;
            WRITE: if (mem_ready || mem_timeout) state_nx = DONE;
            READ:  begin
               if (mem_ready) state_nx = WB;
               else if (mem_timeout) state_nx = DONE;
            end
            WB:    state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      RegOutEn      = '0;
      RegInEn       = '0;
      MARin         = 1'b0;
      MDR_frombusin = 1'b0;
      MDR_frommemin = 1'b0;
      MDRout        = 1'b0;
      EN            = 1'b0;
      RW            = RW_READ;
      busy          = (state != IDLE);
      done          = 1'b0;
      err           = 1'b0;
      case (state)
         ADDR: begin
            RegOutEn = addr_oh;
            MARin    = 1'b1;
         end
         DATA: begin
            RegOutEn      = data_oh;
            MDR_frombusin = 1'b1;
         end
         WRITE: begin
            EN = 1'b1;
            RW = RW_WRITE;
         end
         READ: begin
            EN            = 1'b1;
            RW            = RW_READ;
            MDR_frommemin = 1'b1;
         end
         WB: begin
            MDRout  = 1'b1;
            RegInEn = data_oh;
         end
         DONE: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed bench for mem_xfer_fsm: every output packed into one vector and
// compared cycle by cycle against hand-derived values.
module tb_mem_xfer_fsm;
   import mem_xfer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, mode = 1'b0, mem_ready = 1'b0, abort = 1'b0;
   logic [5:0] addr_sel = '0, data_sel = '0;
   logic [4:0] RegOutEn, RegInEn;
   logic       MARin, MDR_frombusin, MDR_frommemin, MDRout, EN, RW, busy, done, err;
   state_t     state_dbg;

   int total = 0;
   int bad   = 0;

   // flag bits: MARin MDR_frombusin MDR_frommemin MDRout EN RW busy done err
   localparam logic [8:0] F_MAR  = 9'b100000000;
   localparam logic [8:0] F_MDRB = 9'b010000000;
   localparam logic [8:0] F_MDRM = 9'b001000000;
   localparam logic [8:0] F_MDRO = 9'b000100000;
   localparam logic [8:0] F_EN   = 9'b000010000;
   localparam logic [8:0] F_RW   = 9'b000001000;
   localparam logic [8:0] F_BUSY = 9'b000000100;
   localparam logic [8:0] F_DONE = 9'b000000010;
   localparam logic [8:0] F_ERR  = 9'b000000001;

   logic [18:0] obs;
   assign obs = {RegOutEn, RegInEn, MARin, MDR_frombusin, MDR_frommemin, MDRout,
                 EN, RW, busy, done, err};

   mem_xfer_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mode          (mode),
      .addr_sel      (addr_sel),
      .data_sel      (data_sel),
      .mem_ready     (mem_ready),
      .abort         (abort),
      .RegOutEn      (RegOutEn),
      .RegInEn       (RegInEn),
      .MARin         (MARin),
      .MDR_frombusin (MDR_frombusin),
      .MDR_frommemin (MDR_frommemin),
      .MDRout        (MDRout),
      .EN            (EN),
      .RW            (RW),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] ev(logic [4:0] oe, logic [4:0] ie, logic [8:0] f);
      return {oe, ie, f};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic [5:0] a, input logic [5:0] d);
      mode = m; addr_sel = a; data_sel = d; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #3;
      chk("reset_outputs", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));
      #10 rst = 1'b1;
      tick();

      // store r1 -> mem[r2] path, ready already high
      mem_ready = 1'b1;
      issue(MODE_STORE, 6'd1, 6'd2);
      chk("st_addr",  32'(obs), 32'(ev(5'b00010, 5'b0, F_MAR | F_BUSY)));
      tick();
      chk("st_data",  32'(obs), 32'(ev(5'b00100, 5'b0, F_MDRB | F_BUSY)));
      tick();
      chk("st_write", 32'(obs), 32'(ev(5'b0, 5'b0, F_EN | F_RW | F_BUSY)));
      tick();
      chk("st_done",  32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_BUSY)));
      tick();
      chk("st_idle",  32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // load, ready arrives in the 4th READ cycle
      mem_ready = 1'b0;
      issue(MODE_LOAD, 6'd4, 6'd0);
      chk("ld_addr", 32'(obs), 32'(ev(5'b10000, 5'b0, F_MAR | F_BUSY)));
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         chk($sformatf("ld_read%0d", i), 32'(obs), 32'(ev(5'b0, 5'b0, F_EN | F_MDRM | F_BUSY)));
         tick();
      end
      mem_ready = 1'b0;
      chk("ld_wb",   32'(obs), 32'(ev(5'b0, 5'b00001, F_MDRO | F_BUSY)));
      tick();
      chk("ld_done", 32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_BUSY)));
      tick();
      chk("ld_idle", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // load timeout: exactly 8 READ cycles, no WB
      issue(MODE_LOAD, 6'd0, 6'd1);
      chk("to_addr", 32'(obs), 32'(ev(5'b00001, 5'b0, F_MAR | F_BUSY)));
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("to_read%0d", i), 32'(obs), 32'(ev(5'b0, 5'b0, F_EN | F_MDRM | F_BUSY)));
         tick();
      end
      chk("to_done", 32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_ERR | F_BUSY)));
      tick();
      chk("to_idle", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // out-of-range data select
      issue(MODE_STORE, 6'd0, 6'd7);
      chk("bad_done", 32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_ERR | F_BUSY)));
      tick();
      chk("bad_idle", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // abort on WRITE entry, same-register selects
      mem_ready = 1'b1;
      issue(MODE_STORE, 6'd3, 6'd3);
      chk("ab_addr", 32'(obs), 32'(ev(5'b01000, 5'b0, F_MAR | F_BUSY)));
      tick();
      chk("ab_data", 32'(obs), 32'(ev(5'b01000, 5'b0, F_MDRB | F_BUSY)));
      tick();
      abort = 1'b1;
      chk("ab_write", 32'(obs), 32'(ev(5'b0, 5'b0, F_EN | F_RW | F_BUSY)));
      tick();
      abort = 1'b0;
      chk("ab_idle", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));
      tick();
      chk("ab_no_done", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // abort wins over start in IDLE
      abort = 1'b1;
      issue(MODE_STORE, 6'd0, 6'd1);
      abort = 1'b0;
      chk("ab_over_start", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));

      // asynchronous reset mid-READ, then a clean store
      mem_ready = 1'b0;
      issue(MODE_LOAD, 6'd2, 6'd3);
      tick();
      tick();
      chk("rs_read", 32'(obs), 32'(ev(5'b0, 5'b0, F_EN | F_MDRM | F_BUSY)));
      #2 rst = 1'b0;
      #1;
      chk("rs_async", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));
      #3 rst = 1'b1;
      tick();
      mem_ready = 1'b1;
      issue(MODE_STORE, 6'd2, 6'd1);
      chk("rs_addr", 32'(obs), 32'(ev(5'b00100, 5'b0, F_MAR | F_BUSY)));
      tick();
      tick();
      tick();
      chk("rs_done", 32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_BUSY)));
      tick();

      // held start: not taken in DONE, re-triggers from the following IDLE
      mode = MODE_STORE; addr_sel = 6'd0; data_sel = 6'd1; start = 1'b1;
      tick();
      chk("bb_addr", 32'(obs), 32'(ev(5'b00001, 5'b0, F_MAR | F_BUSY)));
      tick();
      tick();
      tick();
      chk("bb_done", 32'(obs), 32'(ev(5'b0, 5'b0, F_DONE | F_BUSY)));
      tick();
      chk("bb_idle", 32'(obs), 32'(ev(5'b0, 5'b0, 9'b0)));
      tick();
      start = 1'b0;
      chk("bb_retrig", 32'(obs), 32'(ev(5'b00001, 5'b0, F_MAR | F_BUSY)));
      abort = 1'b1;
      tick();
      abort = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
